creek_trace_buffer: RTL

CREEK_TRACE_BUFFER -- requirements
Module: creek_trace_buffer

---
 rtl/creek_trace_pkg.sv | 50 +++++
 rtl/creek_trace_buffer_fifo.sv | 71 +++++++
 rtl/creek_trace_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/creek_trace_pkg.sv
// Shared register map, control/status bit positions, capture FSM encoding and trace entry layout
// for the creek trace buffer and its bench.
package creek_trace_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_TRIG_PC = 2'd3;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_CLEAR     = 1;
  localparam int CTRL_TRIG_EN   = 2;
  localparam int CTRL_STOP_FULL = 3;

  localparam int STAT_FULL_BIT  = 16;
  localparam int STAT_EMPTY_BIT = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_FSM_LSB   = 20;
  localparam int STAT_DROP_LSB  = 24;

  localparam int ENT_VLD_BIT   = 31;
  localparam int ENT_STATE_LSB = 26;
  localparam int ENT_PC_LSB    = 16;
  localparam int ENT_INSTR_LSB = 0;

  typedef enum logic [1:0] {
    TR_IDLE      = 2'd0,
    TR_WAIT_TRIG = 2'd1,
    TR_CAPTURE   = 2'd2,
    TR_STOPPED   = 2'd3
  } trace_st_e;

  typedef struct packed {
    logic        vld;
    logic [4:0]  st;
    logic [9:0]  pc;
    logic [15:0] instr;
  } trace_ent_t;

  function automatic trace_ent_t make_entry(input logic [4:0] st, input logic [9:0] pc,
                                            input logic [15:0] instr);
    trace_ent_t e;
    e.vld   = 1'b1;
    e.st    = st;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/creek_trace_buffer_fifo.sv
// Single-clock FIFO with registered read port (pop data valid the cycle after pop) and unreset memory.
// Push accepted when not full or when a pop lands in the same cycle; flush wins over push.
module trace_fifo #(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] pop_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] pop_dat_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = pop_dat_q;
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && !flush_i && (!full_o || do_pop);

  // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    if (do_pop)  pop_dat_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/creek_trace_buffer.sv
// Core trace capture into a FIFO behind a 4-register Avalon-MM slave; read latency 1, no waitrequest.
// A full FIFO either stops capture (stop_on_full) or drops entries and counts them.
module creek_trace_buffer
  import creek_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [9:0]  pc,
  input  logic [4:0]  state,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  trace_st_e     st_q, st_d;
  logic          arm_q, arm_d, trig_en_q, trig_en_d, stop_q, stop_d;
  logic [9:0]    trig_pc_q, trig_pc_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic [14:0]   prev_q;
  logic          first_q, first_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          sel_fifo_q, sel_fifo_d;
  logic          ctrl_wr, clear, push_req, blocked, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_dat;
  logic [31:0]   status;
  trace_ent_t    entry;
  logic          unused_wd;

  assign unused_wd = ^writedata[31:10];
  assign entry     = make_entry(state, pc, instr);

  always_comb begin
    ctrl_wr   = write && (address == REG_CTRL);
    clear     = ctrl_wr && writedata[CTRL_CLEAR];
    arm_d     = ctrl_wr ? writedata[CTRL_ARM] : arm_q;
    trig_en_d = ctrl_wr ? writedata[CTRL_TRIG_EN] : trig_en_q;
    stop_d    = ctrl_wr ? writedata[CTRL_STOP_FULL] : stop_q;
    trig_pc_d = (write && (address == REG_TRIG_PC)) ? writedata[9:0] : trig_pc_q;
    pop       = read && (address == REG_DATA) && !fifo_empty;
    st_d      = st_q;
    first_d   = 1'b0;
    push_req  = 1'b0;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    case (st_q)
      TR_IDLE: begin
        if (arm_d) begin
          st_d    = trig_en_d ? TR_WAIT_TRIG : TR_CAPTURE;
          first_d = !trig_en_d;
        end
      end
      TR_WAIT_TRIG: begin
        if (pc == trig_pc_q) begin
          push_req = 1'b1;
          st_d     = TR_CAPTURE;
        end
      end
      TR_CAPTURE: push_req = first_q || ({pc, state} != prev_q);
      default: ;
    endcase
    // A coincident pop frees the slot, so only a pop-less full push is blocked.
    blocked = push_req && fifo_full && !pop;
    push    = push_req && !blocked && !clear;
    if (blocked) begin
      if (stop_q) begin
        st_d = TR_STOPPED;
      end else begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
    if (clear) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
      if (st_d == TR_STOPPED) st_d = TR_CAPTURE;
    end
    if (ctrl_wr && !writedata[CTRL_ARM]) begin
      st_d    = TR_IDLE;
      first_d = 1'b0;
    end
  end

  always_comb begin
    status                     = '0;
    status[CW-1:0]             = fifo_count;
    status[STAT_FULL_BIT]      = fifo_full;
    status[STAT_EMPTY_BIT]     = fifo_empty;
    status[STAT_OVF_BIT]       = ovf_q;
    status[STAT_FSM_LSB +: 2]  = st_q;
    status[STAT_DROP_LSB +: 8] = drop_q;
  end

  // DATA reads are served straight from the FIFO's registered read port.
  always_comb begin
    rdata_d    = rdata_q;
    sel_fifo_d = sel_fifo_q;
    if (read) begin
      rdata_d    = '0;
      sel_fifo_d = 1'b0;
      case (address)
        REG_CTRL:   rdata_d = {28'd0, stop_q, trig_en_q, 1'b0, arm_q};
        REG_STATUS: rdata_d = status;
        REG_DATA:   sel_fifo_d = !fifo_empty;
        default:    rdata_d = {22'd0, trig_pc_q};
      endcase
    end
  end

  assign readdata = sel_fifo_q ? fifo_dat : rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= TR_IDLE;
      arm_q      <= 1'b0;
      trig_en_q  <= 1'b0;
      stop_q     <= 1'b0;
      trig_pc_q  <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
      prev_q     <= '0;
      first_q    <= 1'b0;
      rdata_q    <= '0;
      sel_fifo_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      arm_q      <= arm_d;
      trig_en_q  <= trig_en_d;
      stop_q     <= stop_d;
      trig_pc_q  <= trig_pc_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      prev_q     <= {pc, state};
      first_q    <= first_d;
      rdata_q    <= rdata_d;
      sel_fifo_q <= sel_fifo_d;
    end
  end

  trace_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW),
    .DW   ($bits(trace_ent_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push_i    (push),
    .push_dat_i(entry),
    .pop_i     (pop),
    .flush_i   (clear),
    .pop_dat_o (fifo_dat),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule
